// File: rtl/dft_vdline_if.sv
// Bundle of configuration, sample input and delayed output signals for dft_vdline.
// Latency: none; this is wiring only.
// Backpressure: none; the delay line accepts every valid sample.
interface dft_vdline_if #(
    parameter int DATA_W = 16,
    parameter int CHAN_N = 1,
    parameter int DEL_W  = 5
);
    logic [DEL_W-1:0]         cfg_delay;
    logic                     cfg_load;
    logic                     flush;
    logic                     din_vld;
    logic [CHAN_N*DATA_W-1:0] din;
    logic                     dout_vld;
    logic [CHAN_N*DATA_W-1:0] dout;
    logic [DEL_W-1:0]         delay_cur;
    logic                     primed;

    modport master (
        output cfg_delay, cfg_load, flush, din_vld, din,
        input  dout_vld, dout, delay_cur, primed
    );

    modport slave (
        input  cfg_delay, cfg_load, flush, din_vld, din,
        output dout_vld, dout, delay_cur, primed
    );
endinterface

// File: rtl/dft_vdline.sv
// Multi-channel delay line with a run-time programmable depth of 0..MAX_STAGES samples.
// Latency: dout is registered one clock after the accepted sample that releases it.
// Backpressure: none; output is gated off until the fill count reaches the delay.
module dft_vdline #(
    parameter int MAX_STAGES = 16,
    parameter int DATA_W     = 16,
    parameter int CHAN_N     = 1,
    parameter int DEF_DELAY  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    dft_vdline_if.slave  bus
);
    localparam int DEL_W = $clog2(MAX_STAGES + 1);
    localparam int W     = CHAN_N * DATA_W;
    localparam logic [DEL_W-1:0] MAX_D = DEL_W'(MAX_STAGES);
    localparam logic [DEL_W-1:0] DEF_D = DEL_W'(DEF_DELAY);

    logic [W-1:0]     line [MAX_STAGES];
    logic [DEL_W-1:0] fill;
    logic [DEL_W-1:0] delay_q;
    logic [W-1:0]     dout_q;
    logic             dout_vld_q;

    logic [DEL_W-1:0] req_d;
    logic [DEL_W-1:0] eff_d;
    logic [DEL_W-1:0] eff_fill;
    logic             eff_primed;
    logic             clear;
    logic [W-1:0]     tap;

    // A load or flush this cycle takes effect before gating the sample arriving with it;
    // the tap is selected from pre-shift contents, with D==0 passing din straight through.
    always_comb begin
        req_d      = (bus.cfg_delay > MAX_D) ? MAX_D : bus.cfg_delay;
        clear      = bus.cfg_load | bus.flush;
        eff_d      = bus.cfg_load ? req_d : delay_q;
        eff_fill   = clear ? '0 : fill;
        eff_primed = (eff_fill >= eff_d);
        tap        = bus.din;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (eff_d == DEL_W'(i + 1)) begin
                tap = line[i];
            end
        end
    end

    // Line shifts, fill counts and output updates happen only on accepted samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_STAGES; i++) begin
                line[i] <= '0;
            end
            fill       <= '0;
            delay_q    <= DEF_D;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            delay_q <= eff_d;
            if (bus.din_vld) begin
                line[0] <= bus.din;
                for (int i = 1; i < MAX_STAGES; i++) begin
                    line[i] <= line[i-1];
                end
                dout_q     <= tap;
                dout_vld_q <= eff_primed;
                fill       <= (eff_fill == MAX_D) ? MAX_D : eff_fill + 1'b1;
            end else begin
                dout_vld_q <= 1'b0;
                fill       <= eff_fill;
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.delay_cur = delay_q;
    assign bus.primed    = (fill >= delay_q);
endmodule
